// File: rtl/byte_lane_data_memory_pkg.sv
// Shared definitions for the byte-lane data memory.
//   - FSM state encoding (clear sequence / normal operation)
//   - clog2 helper for parameter arithmetic
//   - lane_lo helper: LSB index of big-endian byte lane k in a DATA_W word
//     (lane 0 is the most-significant byte, i.e. the byte at the word address)
package byte_lane_data_memory_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

    // Bit index of the least-significant bit of big-endian lane k.
    function automatic int lane_lo(input int data_w, input int lane);
        return data_w - 32'sd8 - (32'sd8 * lane);
    endfunction

endpackage

// File: rtl/byte_lane_data_memory_if.sv
// Request/response bundle between a MEM-stage master and the byte-lane data memory.
//   master: drives mem_req, mem_we, address, byte_en, data_write
//   slave : drives ready, init_busy, data_read, read_valid, align_err
interface byte_lane_data_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) ();
    localparam int BYTES = DATA_W / 8;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] address;
    logic [BYTES-1:0]  byte_en;
    logic [DATA_W-1:0] data_write;
    logic              ready;
    logic              init_busy;
    logic [DATA_W-1:0] data_read;
    logic              read_valid;
    logic              align_err;

    modport master (
        output mem_req, mem_we, address, byte_en, data_write,
        input  ready, init_busy, data_read, read_valid, align_err
    );

    modport slave (
        input  mem_req, mem_we, address, byte_en, data_write,
        output ready, init_busy, data_read, read_valid, align_err
    );
endinterface

// File: rtl/byte_lane_data_memory_mem_byte_lane.sv
// One 8-bit byte lane of the data memory: single-port RAM with a
// registered read port.
//   clk    : clock
//   rst_n  : async active-low reset (clears only the read register)
//   we     : write wdata into row at the rising edge
//   re     : load rdata from row at the rising edge (holds otherwise)
//   row    : word row address
//   wdata  : byte to write
//   rdata  : registered read byte
module mem_byte_lane #(
    parameter int DEPTH_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic               re,
    input  logic [DEPTH_W-1:0] row,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata
);
    logic [7:0] mem_q [2**DEPTH_W];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    // Storage array write port; contents are established by the clear sequencer, not by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[row] <= wdata;
        end
    end

    // Read register next value: load on read, otherwise hold the last byte.
    always_comb begin
        if (re) begin
            rdata_d = mem_q[row];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/byte_lane_data_memory.sv
// Byte-addressed, big-endian data memory with per-byte write enables,
// 1-cycle registered read, misalignment detection and a post-reset clear
// sequencer that zeroes every word before requests are accepted.
//   clk      : clock
//   reset_n  : async active-low reset; restarts the clear sequence
//   bus      : slave side of byte_lane_data_memory_if
//              (mem_req/mem_we/address/byte_en/data_write in;
//               ready/init_busy/data_read/read_valid/align_err out)
module byte_lane_data_memory
    import byte_lane_data_memory_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    byte_lane_data_memory_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = clog2(BYTES);
    localparam int ROW_W = ADDR_W - OFS_W;
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = {ROW_W{1'b1}};

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [ROW_W-1:0] clr_cnt_q;
    logic [ROW_W-1:0] clr_cnt_d;
    logic             read_valid_q;
    logic             read_valid_d;
    logic             align_err_q;
    logic             align_err_d;

    logic              in_init_s;
    logic              accept_s;
    logic              aligned_s;
    logic              wr_s;
    logic              rd_s;
    logic [ROW_W-1:0]  lane_row_s;
    logic [DATA_W-1:0] data_read_s;

    // Request qualification; requests are only accepted once the clear sequence has finished.
    always_comb begin
        in_init_s  = (state_q == ST_INIT);
        accept_s   = bus.mem_req & ~in_init_s;
        aligned_s  = ((bus.address & OFS_MASK) == {ADDR_W{1'b0}});
        wr_s       = accept_s & aligned_s & bus.mem_we;
        rd_s       = accept_s & aligned_s & ~bus.mem_we;
        lane_row_s = in_init_s ? clr_cnt_q : bus.address[ADDR_W-1:OFS_W];
    end

    // Clear sequencer: one row per cycle, then RUN until the next reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + {{(ROW_W-1){1'b0}}, 1'b1};
                if (clr_cnt_q == LAST_ROW) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = {ROW_W{1'b0}};
            end
        endcase
    end

    // Response strobes, valid the cycle after the accepting edge.
    always_comb begin
        read_valid_d = rd_s;
        align_err_d  = accept_s & ~aligned_s;
    end

    // State, clear counter and strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            clr_cnt_q    <= {ROW_W{1'b0}};
            read_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            read_valid_q <= read_valid_d;
            align_err_q  <= align_err_d;
        end
    end

    // Lane k holds the byte at word offset k, which maps to data bits [DATA_W-1-8k -: 8].
    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        logic       lane_we_s;
        logic [7:0] lane_wdata_s;
        logic [7:0] lane_rdata_s;

        // Lane write mux: clear sequencer writes zero to every lane, otherwise user write gated by its byte enable.
        always_comb begin
            if (in_init_s) begin
                lane_we_s    = 1'b1;
                lane_wdata_s = 8'h00;
            end else begin
                lane_we_s    = wr_s & bus.byte_en[BYTES-1-k];
                lane_wdata_s = bus.data_write[lane_lo(DATA_W, k) +: 8];
            end
        end

        mem_byte_lane #(
            .DEPTH_W (ROW_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (reset_n),
            .we    (lane_we_s),
            .re    (rd_s),
            .row   (lane_row_s),
            .wdata (lane_wdata_s),
            .rdata (lane_rdata_s)
        );

        assign data_read_s[lane_lo(DATA_W, k) +: 8] = lane_rdata_s;
    end

    assign bus.ready      = (state_q == ST_RUN);
    assign bus.init_busy  = (state_q == ST_INIT);
    assign bus.data_read  = data_read_s;
    assign bus.read_valid = read_valid_q;
    assign bus.align_err  = align_err_q;

endmodule

// File: tb/tb_byte_lane_data_memory.sv
// Randomized and directed bench for byte_lane_data_memory with two
// instances: 16-bit/8-bit-address and 32-bit/10-bit-address. A byte-array
// model tracks the memory image, the clear-sequence length and the
// expected strobes; a negedge process compares every output every cycle.
module tb_byte_lane_data_memory;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    byte_lane_data_memory_if #(.DATA_W(16), .ADDR_W(8))  if_a ();
    byte_lane_data_memory_if #(.DATA_W(32), .ADDR_W(10)) if_b ();

    byte_lane_data_memory #(.DATA_W(16), .ADDR_W(8)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_a.slave)
    );

    byte_lane_data_memory #(.DATA_W(32), .ADDR_W(10)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_b.slave)
    );

    // ---------------- model ----------------
    logic [7:0]  m [2][1024];
    int          init_left [2];
    bit          exp_valid [2];
    bit          exp_err   [2];
    logic [31:0] exp_data  [2];
    bit          in_rst;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int nwords(input int d);
        return (d == 0) ? 128 : 256;
    endfunction

    task automatic model_reset();
        in_rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            init_left[d] = nwords(d);
            exp_valid[d] = 1'b0;
            exp_err[d]   = 1'b0;
            exp_data[d]  = 32'h0;
            for (int i = 0; i < 1024; i++) m[d][i] = 8'h00;
        end
    endtask

    task automatic model_edge(input int d, input bit req, input bit we, input int addr,
                              input int be, input logic [31:0] wd);
        int  nb;
        bit  rdy;
        nb = nbytes(d);
        if (in_rst) return;
        rdy = (init_left[d] == 0);
        if (init_left[d] > 0) init_left[d]--;
        exp_valid[d] = 1'b0;
        exp_err[d]   = 1'b0;
        if (req && rdy) begin
            if ((addr % nb) != 0) begin
                exp_err[d] = 1'b1;
            end else if (we) begin
                for (int k = 0; k < nb; k++)
                    if (be[nb-1-k]) m[d][addr+k] = wd[8*(nb-1-k) +: 8];
            end else begin
                exp_valid[d] = 1'b1;
                exp_data[d]  = 32'h0;
                for (int k = 0; k < nb; k++)
                    exp_data[d] = (exp_data[d] << 8) | {24'h0, m[d][addr+k]};
            end
        end
    endtask

    // One clock: drive at negedge, model the rising edge, return 1 time unit after it.
    task automatic step(input int d, input bit req, input bit we, input int addr,
                        input int be, input logic [31:0] wd);
        int aa;
        int ab;
        aa = addr & 255;
        ab = addr & 1023;
        @(negedge clk);
        if_a.mem_req    = (d == 0) && req;
        if_a.mem_we     = we;
        if_a.address    = aa[7:0];
        if_a.byte_en    = be[1:0];
        if_a.data_write = wd[15:0];
        if_b.mem_req    = (d == 1) && req;
        if_b.mem_we     = we;
        if_b.address    = ab[9:0];
        if_b.byte_en    = be[3:0];
        if_b.data_write = wd;
        @(posedge clk);
        model_edge(0, (d == 0) && req, we, aa, be, wd);
        model_edge(1, (d == 1) && req, we, ab, be, wd);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_now_dr_a", if_a.data_read, 32'h0);
        chk("rst_now_rv_a", if_a.read_valid, 32'h0);
        chk("rst_now_rdy_a", if_a.ready, 32'h0);
        chk("rst_now_dr_b", if_b.data_read, 32'h0);
        chk("rst_now_rv_b", if_b.read_valid, 32'h0);
    endtask

    task automatic release_reset();
        #2;
        reset_n = 1'b1;
        in_rst  = 1'b0;
    endtask

    // Counts cycles from reset release until each ready rises, issuing reads meanwhile.
    task automatic count_init();
        int n  = 0;
        int na = -1;
        int nb = -1;
        while ((na < 0 || nb < 0) && n < 2000) begin
            step(n % 2, 1'b1, 1'b0, (n * 4) & 63, 0, 32'h0);
            n++;
            if (na < 0 && if_a.ready === 1'b1) na = n;
            if (nb < 0 && if_b.ready === 1'b1) nb = n;
        end
        chk("init_len_a", na, 32'd128);
        chk("init_len_b", nb, 32'd256);
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("ready_a", if_a.ready,      {31'h0, init_left[0] == 0});
            chk("busy_a",  if_a.init_busy,  {31'h0, init_left[0] != 0});
            chk("rv_a",    if_a.read_valid, {31'h0, exp_valid[0]});
            chk("aerr_a",  if_a.align_err,  {31'h0, exp_err[0]});
            chk("data_a",  {16'h0, if_a.data_read}, exp_data[0]);
            chk("ready_b", if_b.ready,      {31'h0, init_left[1] == 0});
            chk("busy_b",  if_b.init_busy,  {31'h0, init_left[1] != 0});
            chk("rv_b",    if_b.read_valid, {31'h0, exp_valid[1]});
            chk("aerr_b",  if_b.align_err,  {31'h0, exp_err[1]});
            chk("data_b",  if_b.data_read,  exp_data[1]);
        end
    end

    initial begin
        reset_n         = 1'b0;
        if_a.mem_req    = 1'b0;
        if_a.mem_we     = 1'b0;
        if_a.address    = 8'h00;
        if_a.byte_en    = 2'b00;
        if_a.data_write = 16'h0000;
        if_b.mem_req    = 1'b0;
        if_b.mem_we     = 1'b0;
        if_b.address    = 10'h000;
        if_b.byte_en    = 4'h0;
        if_b.data_write = 32'h0;
        model_reset();

        for (int i = 0; i < 3; i++) step(i % 2, 1'b1, 1'b0, 4, 0, 32'h0);
        release_reset();
        count_init();

        // Full aligned write then read: big-endian byte placement.
        step(0, 1'b1, 1'b1, 'h06, 'b11, 32'h0000DEBE);
        step(0, 1'b1, 1'b0, 'h06, 0, 32'h0);
        chk("t2_rv", if_a.read_valid, 32'h1);
        chk("t2_data", {16'h0, if_a.data_read}, 32'h0000DEBE);
        chk("t2_model", exp_data[0], 32'h0000DEBE);
        step(0, 1'b1, 1'b1, 'h06, 'b01, 32'h00000000);
        step(0, 1'b1, 1'b0, 'h06, 0, 32'h0);
        chk("t2_byte7", {16'h0, if_a.data_read}, 32'h0000DE00);
        step(0, 1'b1, 1'b1, 'h06, 'b10, 32'h0000FF00);
        step(0, 1'b1, 1'b0, 'h06, 0, 32'h0);
        chk("t2_byte6", {16'h0, if_a.data_read}, 32'h0000FF00);

        // Partial byte-enable merge and be=00 no-op.
        step(0, 1'b1, 1'b1, 'h10, 'b11, 32'h00001234);
        step(0, 1'b1, 1'b1, 'h10, 'b10, 32'h0000AB00);
        step(0, 1'b1, 1'b0, 'h10, 0, 32'h0);
        chk("t3_merge", {16'h0, if_a.data_read}, 32'h0000AB34);
        step(0, 1'b1, 1'b1, 'h10, 'b00, 32'h00005555);
        step(0, 1'b1, 1'b0, 'h10, 0, 32'h0);
        chk("t3_be0", {16'h0, if_a.data_read}, 32'h0000AB34);

        // Misaligned read and write.
        step(0, 1'b1, 1'b0, 'h05, 0, 32'h0);
        chk("t4_aerr", if_a.align_err, 32'h1);
        chk("t4_rv", if_a.read_valid, 32'h0);
        chk("t4_hold", {16'h0, if_a.data_read}, 32'h0000AB34);
        step(0, 1'b1, 1'b1, 'h11, 'b11, 32'h0000FFFF);
        chk("t4_waerr", if_a.align_err, 32'h1);
        step(0, 1'b1, 1'b0, 'h10, 0, 32'h0);
        chk("t4_intact", {16'h0, if_a.data_read}, 32'h0000AB34);

        // Wide instance: top word and streaming reads.
        step(1, 1'b1, 1'b1, 'h3FC, 'hF, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            step(1, 1'b1, 1'b0, 'h3FC, 0, 32'h0);
            chk("t6_rv", if_b.read_valid, 32'h1);
            chk("t6_data", if_b.data_read, 32'hDEADBEEF);
        end

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int d;
            int addr;
            d = $urandom_range(0, 1);
            if (d == 0) addr = $urandom_range(0, 31);
            else        addr = 1024 - $urandom_range(1, 32);
            if ($urandom_range(0, 3) != 0) addr = addr & ~(nbytes(d) - 1);
            step(d, $urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, addr,
                 $urandom, $urandom);
        end

        // Reset in the middle of a read, then again in the middle of the clear.
        step(0, 1'b1, 1'b1, 'h06, 'b11, 32'h00001357);
        step(0, 1'b1, 1'b0, 'h06, 0, 32'h0);
        do_reset();
        for (int i = 0; i < 2; i++) step(i % 2, 1'b1, 1'b0, 8, 0, 32'h0);
        release_reset();
        for (int i = 0; i < 40; i++) step(i % 2, 1'b1, $urandom_range(0, 1) == 1, 8, 'hF, $urandom);
        do_reset();
        step(0, 1'b1, 1'b0, 8, 0, 32'h0);
        release_reset();
        count_init();
        step(0, 1'b1, 1'b0, 'h06, 0, 32'h0);
        chk("t5_rv", if_a.read_valid, 32'h1);
        chk("t5_cleared_a", {16'h0, if_a.data_read}, 32'h0);
        step(1, 1'b1, 1'b0, 'h3FC, 0, 32'h0);
        chk("t5_cleared_b", if_b.data_read, 32'h0);

        for (int i = 0; i < 200; i++) begin
            int d;
            d = $urandom_range(0, 1);
            step(d, 1'b1, $urandom_range(0, 1) == 1,
                 (d == 0) ? $urandom_range(0, 15) * 2 : 1024 - $urandom_range(1, 8) * 4,
                 $urandom, $urandom);
        end

        step(0, 1'b0, 1'b0, 0, 0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
